// File: rtl/sda_axi_lite_reg_bridge_if.sv
// Bus bundles for the AXI4-Lite control bridge: the AXI4-Lite slave port and
// the simple register bus that fans out to the kernel register blocks.

// Every AXI channel transfers on a rising clk edge where valid and ready are
// both high; a source holds valid and payload stable until that edge.
interface sda_axi_lite_if #(
  parameter int AxiAddrWidth = 12
);
  logic                    sAxiAwValid;
  logic                    sAxiAwReady;
  logic [AxiAddrWidth-1:0] sAxiAwAddr;
  logic                    sAxiWValid;
  logic                    sAxiWReady;
  logic [31:0]             sAxiWData;
  logic [3:0]              sAxiWStrb;
  logic                    sAxiBValid;
  logic                    sAxiBReady;
  logic [1:0]              sAxiBResp;
  logic                    sAxiArValid;
  logic                    sAxiArReady;
  logic [AxiAddrWidth-1:0] sAxiArAddr;
  logic                    sAxiRValid;
  logic                    sAxiRReady;
  logic [31:0]             sAxiRData;
  logic [1:0]              sAxiRResp;

  modport slave (
    input  sAxiAwValid, sAxiAwAddr, sAxiWValid, sAxiWData, sAxiWStrb,
           sAxiBReady, sAxiArValid, sAxiArAddr, sAxiRReady,
    output sAxiAwReady, sAxiWReady, sAxiBValid, sAxiBResp,
           sAxiArReady, sAxiRValid, sAxiRData, sAxiRResp
  );

  modport master (
    output sAxiAwValid, sAxiAwAddr, sAxiWValid, sAxiWData, sAxiWStrb,
           sAxiBReady, sAxiArValid, sAxiArAddr, sAxiRReady,
    input  sAxiAwReady, sAxiWReady, sAxiBValid, sAxiBResp,
           sAxiArReady, sAxiRValid, sAxiRData, sAxiRResp
  );
endinterface

interface sda_reg_bus_if #(
  parameter int RegAddrWidth = 8
);
  logic                    regReq;
  logic                    regAck;
  logic                    regWriteEn;
  logic [RegAddrWidth-1:0] regAddr;
  logic [31:0]             regWData;
  logic [31:0]             regRData;

  modport master (
    output regReq, regWriteEn, regAddr, regWData,
    input  regAck, regRData
  );

  modport slave (
    input  regReq, regWriteEn, regAddr, regWData,
    output regAck, regRData
  );
endinterface

// File: rtl/sda_axi_lite_reg_bridge.sv
// AXI4-Lite slave that turns each read or write into a single request on the
// register bus, one at a time, with strobe rejection and an ack timeout.
module sda_axi_lite_reg_bridge #(
  parameter int AxiAddrWidth  = 12,
  parameter int RegAddrWidth  = 8,
  parameter int TimeoutCycles = 256
) (
  input  logic          clk,
  input  logic          srstn,
  sda_axi_lite_if.slave axi,
  sda_reg_bus_if.master rbus,
  output logic [2:0]    dbg_state
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_e;

  localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 1);

  state_e                  state_q, state_d;
  logic                    wr_prio_q, wr_prio_d;
  logic                    aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic [RegAddrWidth-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [31:0]             w_data_q, w_data_d;
  logic [3:0]              w_strb_q, w_strb_d;
  logic                    aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, ar_ready_q, ar_ready_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    req_q, req_d, we_q, we_d;
  logic [RegAddrWidth-1:0] addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]             rdata_q, rdata_d;

  logic wr_elig, rd_elig, timeout_hit;
  assign wr_elig     = aw_held_q && w_held_q;
  assign rd_elig     = ar_held_q;
  assign timeout_hit = (cnt_q == TimeoutLast);

  always_comb begin
    state_d   = state_q;
    wr_prio_d = wr_prio_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    ar_held_d = ar_held_q;
    aw_addr_d = aw_addr_q;
    ar_addr_d = ar_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;

    if (axi.sAxiAwValid && aw_ready_q) begin
      aw_held_d = 1'b1;
      aw_addr_d = axi.sAxiAwAddr[RegAddrWidth-1:0];
    end
    if (axi.sAxiWValid && w_ready_q) begin
      w_held_d = 1'b1;
      w_data_d = axi.sAxiWData;
      w_strb_d = axi.sAxiWStrb;
    end
    if (axi.sAxiArValid && ar_ready_q) begin
      ar_held_d = 1'b1;
      ar_addr_d = axi.sAxiArAddr[RegAddrWidth-1:0];
    end

    case (state_q)
      IDLE: begin
        // wr_prio_q is set after reset and after every serviced read.
        if (wr_elig && (wr_prio_q || !rd_elig)) begin
          wr_prio_d = 1'b0;
          if (w_strb_q != 4'hF) begin
            state_d  = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
          end else begin
            state_d = WR_REQ;
            req_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = aw_addr_q;
            wdata_d = w_data_q;
            cnt_d   = '0;
          end
        end else if (rd_elig) begin
          wr_prio_d = 1'b1;
          state_d   = RD_REQ;
          req_d     = 1'b1;
          we_d      = 1'b0;
          addr_d    = ar_addr_q;
          wdata_d   = '0;
          cnt_d     = '0;
        end
      end
      WR_REQ, RD_REQ: begin
        // An ack in the timeout cycle still counts as a successful transfer.
        if (rbus.regAck || timeout_hit) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          cnt_d   = '0;
          if (state_q == WR_REQ) begin
            state_d  = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = rbus.regAck ? 2'b00 : 2'b10;
          end else begin
            state_d  = RD_RESP;
            rvalid_d = 1'b1;
            rresp_d  = rbus.regAck ? 2'b00 : 2'b10;
            rdata_d  = rbus.regAck ? rbus.regRData : 32'd0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      WR_RESP: begin
        if (axi.sAxiBReady) begin
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      RD_RESP: begin
        if (axi.sAxiRReady) begin
          rvalid_d  = 1'b0;
          rresp_d   = 2'b00;
          rdata_d   = '0;
          ar_held_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A channel accepts a new beat only while its holding register is free.
    aw_ready_d = !aw_held_d;
    w_ready_d  = !w_held_d;
    ar_ready_d = !ar_held_d;
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= IDLE;
      wr_prio_q  <= 1'b1;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      ar_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      ar_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      ar_ready_q <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_prio_q  <= wr_prio_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      ar_held_q  <= ar_held_d;
      aw_addr_q  <= aw_addr_d;
      ar_addr_q  <= ar_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      ar_ready_q <= ar_ready_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign axi.sAxiAwReady = aw_ready_q;
  assign axi.sAxiWReady  = w_ready_q;
  assign axi.sAxiArReady = ar_ready_q;
  assign axi.sAxiBValid  = bvalid_q;
  assign axi.sAxiBResp   = bresp_q;
  assign axi.sAxiRValid  = rvalid_q;
  assign axi.sAxiRData   = rdata_q;
  assign axi.sAxiRResp   = rresp_q;
  assign rbus.regReq     = req_q;
  assign rbus.regWriteEn = we_q;
  assign rbus.regAddr    = addr_q;
  assign rbus.regWData   = wdata_q;
  assign dbg_state       = state_q;

  // Address bits above the register window are deliberately dropped.
  if (AxiAddrWidth > RegAddrWidth) begin : g_addr_unused
    logic unused_addr_hi;
    assign unused_addr_hi = ^{axi.sAxiAwAddr[AxiAddrWidth-1:RegAddrWidth],
                              axi.sAxiArAddr[AxiAddrWidth-1:RegAddrWidth]};
  end
endmodule

// File: tb/tb_sda_axi_lite_reg_bridge.sv
// Bench for sda_axi_lite_reg_bridge: directed AXI traffic plus random mixes,
// against a register-block responder and an address-indexed memory model.
module tb_sda_axi_lite_reg_bridge;
  localparam int AW = 12;
  localparam int RW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic srstn = 1'b0;
  always #5 clk = ~clk;

  sda_axi_lite_if #(.AxiAddrWidth(AW)) axi ();
  sda_reg_bus_if  #(.RegAddrWidth(RW)) rbus ();
  logic [2:0] dbg_state;

  sda_axi_lite_reg_bridge #(
    .AxiAddrWidth (AW),
    .RegAddrWidth (RW),
    .TimeoutCycles(TO)
  ) dut (
    .clk      (clk),
    .srstn    (srstn),
    .axi      (axi.slave),
    .rbus     (rbus.master),
    .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } txn_t;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] reg_mem [256];
  logic [31:0] exp_mem [256];
  bit          ack_en = 1'b1;
  int          ack_on = 3;
  bit          inject_ack = 1'b0;
  int          req_high = 0;
  int          req_run = 0;
  int          unstable = 0;
  int          idle_dirty = 0;
  txn_t        txn_log[$];
  txn_t        cur_txn, first_txn;
  bit          last_was_read = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register block: acks on the ack_on-th request cycle, unless disabled.
  initial begin
    rbus.regAck   = 1'b0;
    rbus.regRData = '0;
    forever begin
      @(posedge clk);
      #2;
      rbus.regAck   = 1'b0;
      rbus.regRData = '0;
      if (rbus.regReq) begin
        req_high++;
        req_run++;
        cur_txn = '{we: rbus.regWriteEn, addr: rbus.regAddr, wdata: rbus.regWData};
        if (req_run == 1) first_txn = cur_txn;
        else if (cur_txn != first_txn) unstable++;
        if (ack_en && req_run == ack_on) begin
          rbus.regAck = 1'b1;
          if (cur_txn.we) reg_mem[cur_txn.addr] = cur_txn.wdata;
          else rbus.regRData = reg_mem[cur_txn.addr];
          txn_log.push_back(cur_txn);
        end
      end else begin
        req_run = 0;
        if (rbus.regAddr != '0 || rbus.regWData != '0) idle_dirty++;
        rbus.regAck   = inject_ack;
        rbus.regRData = inject_ack ? 32'hDEAD_BEEF : 32'd0;
      end
    end
  end

  task automatic send_aw(input logic [AW-1:0] a);
    int n = 0;
    axi.sAxiAwValid = 1'b1;
    axi.sAxiAwAddr  = a;
    while (!axi.sAxiAwReady && n < 100) begin tick(); n++; end
    chk("aw_accept", 64'(n < 100), 64'd1);
    tick();
    axi.sAxiAwValid = 1'b0;
    axi.sAxiAwAddr  = '0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.sAxiWValid = 1'b1;
    axi.sAxiWData  = d;
    axi.sAxiWStrb  = s;
    while (!axi.sAxiWReady && n < 100) begin tick(); n++; end
    chk("w_accept", 64'(n < 100), 64'd1);
    tick();
    axi.sAxiWValid = 1'b0;
    axi.sAxiWData  = '0;
    axi.sAxiWStrb  = '0;
  endtask

  task automatic send_ar(input logic [AW-1:0] a);
    int n = 0;
    axi.sAxiArValid = 1'b1;
    axi.sAxiArAddr  = a;
    while (!axi.sAxiArReady && n < 100) begin tick(); n++; end
    chk("ar_accept", 64'(n < 100), 64'd1);
    tick();
    axi.sAxiArValid = 1'b0;
    axi.sAxiArAddr  = '0;
  endtask

  task automatic get_b(output logic [1:0] resp, output int lat);
    int n = 0;
    axi.sAxiBReady = 1'b1;
    while (!axi.sAxiBValid && n < 200) begin tick(); n++; end
    chk("b_arrive", 64'(n < 200), 64'd1);
    resp = axi.sAxiBResp;
    lat  = n;
    tick();
    axi.sAxiBReady = 1'b0;
  endtask

  task automatic get_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    axi.sAxiRReady = (hold == 0);
    while (!axi.sAxiRValid && n < 200) begin tick(); n++; end
    chk("r_arrive", 64'(n < 200), 64'd1);
    data = axi.sAxiRData;
    resp = axi.sAxiRResp;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("r_hold", {axi.sAxiRValid, axi.sAxiRData, axi.sAxiRResp}, {1'b1, data, resp});
    end
    axi.sAxiRReady = 1'b1;
    tick();
    axi.sAxiRReady = 1'b0;
    chk("r_clear", {axi.sAxiRValid, axi.sAxiRData}, '0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int ackon, input int wlead, output int lat, output int req_delta);
    logic [1:0] resp, exp_resp;
    int base;
    bit ok;
    ack_on = ackon;
    base   = req_high;
    txn_log.delete();
    ok       = (s == 4'hF) && ack_en && (ackon <= TO);
    exp_resp = ok ? 2'b00 : 2'b10;
    if (wlead > 0) begin
      send_w(d, s);
      for (int i = 0; i < wlead; i++) tick();
      chk("w_first_no_req", 64'(req_high - base), 64'd0);
      chk("w_first_readies", {axi.sAxiAwReady, axi.sAxiWReady}, 2'b10);
      send_aw(a);
    end else begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end
    chk("wr_readies_low", {axi.sAxiAwReady, axi.sAxiWReady}, 2'b00);
    get_b(resp, lat);
    chk("bresp", resp, exp_resp);
    chk("wr_readies_back", {axi.sAxiAwReady, axi.sAxiWReady}, 2'b11);
    chk("wr_txn_count", txn_log.size(), ok ? 1 : 0);
    if (ok && txn_log.size() == 1) chk("wr_txn", txn_log[0], {1'b1, a[7:0], d});
    if (ok) exp_mem[a[7:0]] = d;
    last_was_read = 1'b0;
    req_delta = req_high - base;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ackon, input int hold, output int req_delta);
    logic [31:0] d, exp_d;
    logic [1:0]  resp;
    int base;
    bit ok;
    ack_on = ackon;
    base   = req_high;
    txn_log.delete();
    ok    = ack_en && (ackon <= TO);
    exp_d = ok ? exp_mem[a[7:0]] : 32'd0;
    send_ar(a);
    chk("ar_ready_low", axi.sAxiArReady, 1'b0);
    get_r(hold, d, resp);
    chk("rdata", d, exp_d);
    chk("rresp", resp, ok ? 2'b00 : 2'b10);
    chk("ar_ready_back", axi.sAxiArReady, 1'b1);
    chk("rd_txn_count", txn_log.size(), ok ? 1 : 0);
    if (ok && txn_log.size() == 1) chk("rd_txn", txn_log[0][40:32], {1'b0, a[7:0]});
    last_was_read = 1'b1;
    req_delta = req_high - base;
  endtask

  task automatic do_both(input logic [AW-1:0] wa, input logic [31:0] wd,
                         input logic [AW-1:0] ra, input int ackon);
    bit          wfirst;
    logic [31:0] exp_rd, rd;
    logic [1:0]  bresp, rresp;
    int          lat;
    wfirst = last_was_read;
    ack_on = ackon;
    txn_log.delete();
    exp_rd = (wfirst && wa[7:0] == ra[7:0]) ? wd : exp_mem[ra[7:0]];
    fork
      send_aw(wa);
      send_w(wd, 4'hF);
      send_ar(ra);
    join
    fork
      get_b(bresp, lat);
      get_r(0, rd, rresp);
    join
    chk("both_bresp", bresp, 2'b00);
    chk("both_rresp", rresp, 2'b00);
    chk("both_rdata", rd, exp_rd);
    chk("both_txns", txn_log.size(), 2);
    if (txn_log.size() == 2) chk("both_order", txn_log[0].we, wfirst);
    exp_mem[wa[7:0]] = wd;
    last_was_read = wfirst;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rq, n;
    logic [AW-1:0] a, a2;
    logic [31:0]   d;
    logic [3:0]    s;

    for (int i = 0; i < 256; i++) begin
      reg_mem[i] = '0;
      exp_mem[i] = '0;
    end
    axi.sAxiAwValid = 1'b0; axi.sAxiAwAddr = '0;
    axi.sAxiWValid  = 1'b0; axi.sAxiWData  = '0; axi.sAxiWStrb = '0;
    axi.sAxiBReady  = 1'b0;
    axi.sAxiArValid = 1'b0; axi.sAxiArAddr = '0;
    axi.sAxiRReady  = 1'b0;

    repeat (3) tick();
    chk("rst_ctrl", {axi.sAxiAwReady, axi.sAxiWReady, axi.sAxiArReady, axi.sAxiBValid,
                     axi.sAxiRValid, rbus.regReq, rbus.regWriteEn}, '0);
    chk("rst_rdata", {axi.sAxiRData, axi.sAxiBResp, axi.sAxiRResp}, '0);
    chk("rst_reg", {rbus.regWData, rbus.regAddr}, '0);
    srstn = 1'b1;
    tick();
    chk("readies_after_rst", {axi.sAxiAwReady, axi.sAxiWReady, axi.sAxiArReady}, 3'b111);

    // Basic write, ack on third request cycle
    do_write(12'h000, 32'h1, 4'hF, 3, 0, lat, rq);
    chk("wr_req_cycles", rq, 3);
    chk("wr_latency", lat, 4);

    // Read held while RReady stays low
    reg_mem[0] = 32'h0000_000C;
    exp_mem[0] = 32'h0000_000C;
    do_read(12'h000, 2, 4, rq);
    chk("rd_req_cycles", rq, 2);

    // W three cycles ahead of AW
    do_write(12'h004, 32'hA5, 4'hF, 2, 3, lat, rq);
    chk("wfirst_req_cycles", rq, 2);

    // Ack on the timeout cycle wins; one cycle later is too late
    do_write(12'h010, 32'h1234_5678, 4'hF, TO, 0, lat, rq);
    chk("ack_at_limit_cycles", rq, TO);
    do_write(12'h014, 32'h0BAD_0BAD, 4'hF, TO + 1, 0, lat, rq);
    chk("ack_past_limit_cycles", rq, TO);

    // Timeouts with no ack at all, then a stray late ack
    ack_en = 1'b0;
    do_write(12'h008, 32'h55, 4'hF, 3, 0, lat, rq);
    chk("wr_timeout_cycles", rq, TO);
    repeat (5) tick();
    inject_ack = 1'b1;
    tick();
    inject_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_ack_ignored", {axi.sAxiBValid, axi.sAxiRValid, rbus.regReq, axi.sAxiRData}, '0);
    end
    do_read(12'h008, 3, 1, rq);
    chk("rd_timeout_cycles", rq, TO);
    ack_en = 1'b1;

    // Partial strobes never reach the register bus
    do_write(12'h00C, 32'hFFFF_FFFF, 4'h3, 3, 0, lat, rq);
    chk("strb_no_req", rq, 0);
    chk("strb_latency", lat, 1);

    // Reset while a request is outstanding
    ack_en = 1'b0;
    send_ar(12'h010);
    n = 0;
    while (!rbus.regReq && n < 20) begin tick(); n++; end
    chk("req_seen_before_rst", rbus.regReq, 1'b1);
    srstn = 1'b0;
    tick();
    chk("midrst_ctrl", {axi.sAxiAwReady, axi.sAxiWReady, axi.sAxiArReady, axi.sAxiBValid,
                        axi.sAxiRValid, rbus.regReq, rbus.regWriteEn}, '0);
    chk("midrst_reg", {rbus.regWData, rbus.regAddr}, '0);
    srstn = 1'b1;
    tick();
    chk("readies_after_midrst", {axi.sAxiAwReady, axi.sAxiWReady, axi.sAxiArReady}, 3'b111);
    ack_en = 1'b1;
    last_was_read = 1'b1;

    // Simultaneous traffic right after reset, then after a lone write
    do_both(12'h020, 32'hCAFE_0001, 12'h010, 2);
    do_write(12'h024, 32'h7777, 4'hF, 1, 0, lat, rq);
    do_both(12'h010, 32'hCAFE_0002, 12'h010, 3);
    do_read(12'h000, 1, 0, rq);

    // Random mix checked against the memory model
    for (int it = 0; it < 60; it++) begin
      a  = {4'($urandom), 8'($urandom_range(0, 7) * 4)};
      a2 = {4'($urandom), 8'($urandom_range(0, 7) * 4)};
      d  = $urandom;
      case ($urandom_range(0, 3))
        0: do_write(a, d, 4'hF, $urandom_range(1, 5), $urandom_range(0, 2), lat, rq);
        1: begin
          s = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom_range(0, 14));
          do_write(a, d, s, $urandom_range(1, 5), 0, lat, rq);
        end
        2: do_read(a, $urandom_range(1, 5), $urandom_range(0, 2), rq);
        default: do_both(a, d, a2, $urandom_range(1, 4));
      endcase
    end

    chk("req_payload_stable", unstable, 0);
    chk("idle_bus_zero", idle_dirty, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sda_axi_lite_reg_bridge.md
Name: sda_axi_lite_reg_bridge

Overview:
AXI4-Lite slave that terminates the SDAccel kernel control port and converts each AXI read or write into one transaction on the team's simple register bus (regReq/regAck/regWriteEn/regAddr/regWData/regRData). It sits directly upstream of the kernel control register block and any sibling register blocks, whose regAck/regRData outputs are ORed together. It serialises reads and writes, rejects unsupported byte-strobe writes, and times out transactions that no block acknowledges.

Parameters:
AxiAddrWidth, 12, width of AXI byte address; must be >= RegAddrWidth
RegAddrWidth, 8, width of regAddr; regAddr = AXI address[RegAddrWidth-1:0], byte address, no shifting
TimeoutCycles, 256, cycles regReq may stay high without regAck before an error response; legal range 1..65535

Ports:
clk  in  1  system clock
srstn  in  1  synchronous reset, active low
sAxiAwValid  in  1  write address valid
sAxiAwReady  out  1  write address ready
sAxiAwAddr  in  AxiAddrWidth  write address
sAxiWValid  in  1  write data valid
sAxiWReady  out  1  write data ready
sAxiWData  in  32  write data
sAxiWStrb  in  4  write byte strobes
sAxiBValid  out  1  write response valid
sAxiBReady  in  1  write response ready
sAxiBResp  out  2  write response (00 OKAY, 10 SLVERR)
sAxiArValid  in  1  read address valid
sAxiArReady  out  1  read address ready
sAxiArAddr  in  AxiAddrWidth  read address
sAxiRValid  out  1  read data valid
sAxiRReady  in  1  read data ready
sAxiRData  out  32  read data
sAxiRResp  out  2  read response
regReq  out  1  register request, held until acknowledged
regAck  in  1  ORed acknowledge from register blocks
regWriteEn  out  1  1 = write, 0 = read
regAddr  out  RegAddrWidth  register byte address
regWData  out  32  write data
regRData  in  32  ORed read data, valid while regAck high

Behaviour:
- One clock (clk); reset synchronous, active low (srstn). All outputs registered.
- Reset values: every output 0. sAxiAwReady, sAxiWReady, sAxiArReady rise the first cycle after srstn goes high.
- AW and W captured independently, either order, into holding regs; each ready drops the cycle after its handshake and stays low until that write's B handshake completes.
- AR captured into a holding reg; ArReady drops after handshake, returns after the R handshake.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP. Only one register transaction is in flight at a time.
- IDLE: write is eligible when AW and W are both held; read when AR is held. If both are eligible, round robin decides: write wins when the last serviced transaction was a read or after reset; otherwise read wins.
- Eligible write with WStrb != 4'hF: no regReq is issued; go to WR_RESP with BResp = 10.
- WR_REQ/RD_REQ: regReq = 1, regWriteEn/regAddr/regWData stable from the first cycle after entry. Timeout counter starts at 0 and increments each cycle.
- regAck sampled high: next cycle regReq = 0. For a read, RData <= regRData and RResp = 00; for a write, BResp = 00. Enter the RESP state.
- Counter reaches TimeoutCycles with no ack: next cycle regReq = 0, response is SLVERR (10) and, for a read, RData = 0.
- regAck and timeout on the same cycle: ack wins and the response is OKAY.
- regAck outside a REQ state is ignored. A late ack after a timeout has no effect.
- regWData and regAddr return to 0 whenever regReq is 0.
- WR_RESP: BValid = 1, held until BReady. On handshake, BValid = 0, AwReady and WReady are restored, and the state returns to IDLE.
- RD_RESP: the same handshake on the R channel; RValid and RData are held stable until RReady. RData is cleared on exit.
- Latency with a block that acks 2 cycles after regReq rises: AW+W both captured at edge N; regReq high cycles N+1..N+3; BValid at N+4.
- Reset mid-transaction: all state and outputs return to reset values the next cycle and the pending transaction is discarded.

Test Plan:
- Write 0x00 data 0x1 strb 0xF; model acks on the 3rd regReq cycle -> regReq high exactly 3 cycles with regWriteEn=1, regAddr=0x00, regWData=0x1; BValid next cycle, BResp=00.
- Read 0x00; model returns regRData=0x0000000C with ack -> RData=0x0000000C, RResp=00, held 4 cycles while RReady=0, then cleared after handshake.
- W sent 3 cycles before AW (addr 0x04, data 0xA5) -> single regReq issued only after AW captured; BResp=00; AwReady and WReady low until B handshake.
- TimeoutCycles=16, no ack -> regReq drops after 16 cycles; BResp=10 for a write; RData=0 and RResp=10 for a read; an ack injected 5 cycles later has no effect.
- Write with WStrb=0x3 -> regReq never asserted; BResp=10. Simultaneous AR and AW/W after reset -> write serviced first, then read; repeated simultaneous traffic alternates.
- srstn low while regReq high -> next cycle regReq=0, all valids/readies=0; after release, readies=1 and a fresh read completes normally.
